// File: rtl/mem_port_scheduler_pkg.sv
// Shared types and constants for the memory port scheduler.
// Optional read watchdog: define MEM_PORT_SCHEDULER_TIMEOUT_EN.
package mem_port_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_e;

  // Width of the read-response watchdog counter (covers TIMEOUT_CYCLES up to 65535).
  localparam int TO_CNT_W = 16;

  // Round-robin successor of a requester index.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_port_scheduler_rr_arbiter.sv
// Combinational round-robin pick: nearest requesting index at or above the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic               o_vld,
  output logic [PTR_W-1:0]   o_idx
);

  logic [PTR_W-1:0] w_cand;

  // Scan from the farthest offset back to the pointer so the last hit is the winner.
  always_comb begin
    o_vld  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_cand]) begin
        o_vld = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_scheduler.sv
// Single-outstanding memory port scheduler with round-robin arbitration.
// Optional read watchdog: define MEM_PORT_SCHEDULER_TIMEOUT_EN.
module mem_port_scheduler
  import mem_port_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                clk_i,
  input  logic                                arst_n_i,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ-1:0]                  req_we_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  output logic [DATA_WIDTH-1:0]               rdata_o,
  output logic                                err_o,
  output logic                                mem_read_o,
  output logic                                mem_write_o,
  output logic [ADDR_WIDTH-1:0]               mem_addr_o,
  output logic [DATA_WIDTH-1:0]               mem_wdata_o,
  input  logic                                mem_waitrequest_i,
  input  logic                                mem_rdatavalid_i,
  input  logic [DATA_WIDTH-1:0]               mem_rdata_i,
  output logic                                busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                 r_state, w_state_nxt;
  logic [PTR_W-1:0]       r_rr_ptr, r_win;
  logic                   r_we;
  logic [NUM_REQ-1:0]     r_gnt;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic                   r_mem_read, r_mem_write;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [DATA_WIDTH-1:0]  r_mem_wdata;

  logic [NUM_REQ-1:0]     w_req_eff;
  logic                   w_pick_vld;
  logic [PTR_W-1:0]       w_pick_idx;
  logic                   w_start, w_accept, w_rd_done, w_timeout, w_to_hit;
  logic                   w_complete;

  // The requester being granted this cycle still holds req_i; keep it out of
  // the back-to-back arbitration so it is not served twice.
  assign w_req_eff = req_i & ~r_gnt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_req (w_req_eff),
    .i_ptr (r_rr_ptr),
    .o_vld (w_pick_vld),
    .o_idx (w_pick_idx)
  );

`ifdef MEM_PORT_SCHEDULER_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_to_cnt;
  logic                r_err;

  // Count cycles spent waiting for read data; cleared whenever not waiting.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)                  r_to_cnt <= '0;
    else if (r_state != ST_WAIT_RD) r_to_cnt <= '0;
    else                            r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Error flag pulses alongside the grant of a timed-out read.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_err <= 1'b0;
    else           r_err <= w_timeout;
  end

  assign w_to_hit = (r_to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_o    = r_err;
`else
  assign w_to_hit = 1'b0;
  assign err_o    = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_pick_vld) w_state_nxt = ST_CMD;
      ST_CMD:     if (!mem_waitrequest_i) w_state_nxt = r_we ? ST_IDLE : ST_WAIT_RD;
      ST_WAIT_RD: if (mem_rdatavalid_i || w_to_hit) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output/control decode; read data has priority over the watchdog.
  always_comb begin
    w_start   = 1'b0;
    w_accept  = 1'b0;
    w_rd_done = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE:    w_start   = w_pick_vld;
      ST_CMD:     w_accept  = !mem_waitrequest_i;
      ST_WAIT_RD: begin
        w_rd_done = mem_rdatavalid_i;
        w_timeout = !mem_rdatavalid_i && w_to_hit;
      end
      default: ;
    endcase
  end

  assign w_complete = (w_accept && r_we) || w_rd_done || w_timeout;

  // Latch the winner's command and hold the strobes until the memory accepts.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_win       <= '0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (w_start) begin
      r_win       <= w_pick_idx;
      r_we        <= req_we_i[w_pick_idx];
      r_mem_addr  <= req_addr_i[w_pick_idx];
      r_mem_wdata <= req_wdata_i[w_pick_idx];
      r_mem_read  <= !req_we_i[w_pick_idx];
      r_mem_write <= req_we_i[w_pick_idx];
    end else if (w_accept) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end
  end

  // Completion: one-hot grant pulse and pointer advance past the winner.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_gnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_gnt <= w_complete ? (NUM_REQ'(1) << r_win) : '0;
      if (w_complete) r_rr_ptr <= PTR_W'(rr_next(int'(r_win), NUM_REQ));
    end
  end

  // Read data register; holds between read completions, zeroed on timeout.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)      r_rdata <= '0;
    else if (w_rd_done) r_rdata <= mem_rdata_i;
    else if (w_timeout) r_rdata <= '0;
  end

  assign gnt_o       = r_gnt;
  assign rdata_o     = r_rdata;
  assign mem_read_o  = r_mem_read;
  assign mem_write_o = r_mem_write;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed + randomized bench for mem_port_scheduler with a transaction-level model.
module tb_mem_port_scheduler;
  localparam int NR = 4, AW = 23, DW = 16, TO = 16;

  logic                 clk_i = 1'b0, arst_n_i = 1'b1;
  logic [NR-1:0]        req_i = '0, req_we_i = '0;
  logic [NR-1:0][AW-1:0] req_addr_i = '0;
  logic [NR-1:0][DW-1:0] req_wdata_i = '0;
  logic [NR-1:0]        gnt_o;
  logic [DW-1:0]        rdata_o;
  logic                 err_o, mem_read_o, mem_write_o, busy_o;
  logic [AW-1:0]        mem_addr_o;
  logic [DW-1:0]        mem_wdata_o;
  logic                 mem_waitrequest_i = 1'b0, mem_rdatavalid_i = 1'b0;
  logic [DW-1:0]        mem_rdata_i = '0;

  int checks = 0, failures = 0;
  // memory responder knobs (written by main sequence only)
  int cfg_wait = 0, cfg_lat = 3;
  bit cfg_answer = 1'b1, cfg_spur = 1'b0;
  // last accepted command (written by responder only)
  int acc_cnt = 0;
  logic acc_we = 1'b0;
  logic [AW-1:0] acc_addr = '0;
  logic [DW-1:0] acc_wdata = '0;
  // reference model state
  int m_ptr = 0;
  logic [DW-1:0] exp_rdata = '0;

  mem_port_scheduler #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .req_i(req_i), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .gnt_o(gnt_o), .rdata_o(rdata_o),
    .err_o(err_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_waitrequest_i(mem_waitrequest_i),
    .mem_rdatavalid_i(mem_rdatavalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o));

  initial forever #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hC35A;
  endfunction

  // round-robin rule: first requester at or after pointer, wrapping
  function automatic int pick(input logic [NR-1:0] s, input int p);
    int i;
    for (int k = 0; k < NR; k++) begin
      i = (p + k) % NR;
      if (s[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},   32'(gnt_o), 0);
    chk({tag, "_rdata"}, 32'(rdata_o), 0);
    chk({tag, "_err"},   32'(err_o), 0);
    chk({tag, "_rd"},    32'(mem_read_o), 0);
    chk({tag, "_wr"},    32'(mem_write_o), 0);
    chk({tag, "_addr"},  32'(mem_addr_o), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata_o), 0);
    chk({tag, "_busy"},  32'(busy_o), 0);
  endtask

  task automatic do_reset();
    req_i = '0;
    arst_n_i = 1'b0;
    #1;
    chk_zero("rst");
    step(); step();
    arst_n_i = 1'b1;
    m_ptr = 0;
    exp_rdata = '0;
    step();
  endtask

  task automatic wait_gnt(input int bound, output int cyc, output bit got);
    got = 1'b0; cyc = 0;
    while (!got && cyc < bound) begin
      step(); cyc++;
      if (gnt_o != '0) got = 1'b1;
    end
  endtask

  // memory slave: waitrequest stretching, read latency, spurious valid
  initial begin : mem_model
    bit in_cmd; int wl, rd_cnt; logic [DW-1:0] rd_data;
    in_cmd = 1'b0; wl = 0; rd_cnt = 0; rd_data = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_rdatavalid_i = 1'b0;
      if (!arst_n_i) begin
        in_cmd = 1'b0; rd_cnt = 0; mem_waitrequest_i = 1'b0;
      end else begin
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin mem_rdatavalid_i = 1'b1; mem_rdata_i = rd_data; end
        end
        if (cfg_spur) begin mem_rdatavalid_i = 1'b1; mem_rdata_i = 16'hDEAD; end
        if (mem_read_o || mem_write_o) begin
          if (!in_cmd) begin in_cmd = 1'b1; wl = cfg_wait; end
          if (wl > 0) begin mem_waitrequest_i = 1'b1; wl--; end
          else begin
            mem_waitrequest_i = 1'b0; in_cmd = 1'b0; acc_cnt++;
            acc_we = mem_write_o; acc_addr = mem_addr_o; acc_wdata = mem_wdata_o;
            if (mem_read_o && cfg_answer) begin rd_cnt = cfg_lat; rd_data = rd_val(mem_addr_o); end
          end
        end else mem_waitrequest_i = 1'b0;
      end
    end
  end

  initial begin : main
    int cyc, ng, w, hi, bad, gcnt;
    bit got;
    logic [NR-1:0] snap, eg, last_g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int ord[5];
    ord = '{0, 1, 2, 3, 0};

    #3;
    do_reset();

    // single write, 2-cycle req-to-gnt
    req_we_i[0] = 1'b1; req_addr_i[0] = 23'h10; req_wdata_i[0] = 16'hABCD; req_i = 4'b0001;
    step();
    chk("w1_wr_strobe", 32'(mem_write_o), 1);
    chk("w1_rd_strobe", 32'(mem_read_o), 0);
    chk("w1_addr", 32'(mem_addr_o), 32'h10);
    chk("w1_wdata", 32'(mem_wdata_o), 32'hABCD);
    chk("w1_early_gnt", 32'(gnt_o), 0);
    chk("w1_busy", 32'(busy_o), 1);
    step();
    chk("w1_gnt", 32'(gnt_o), 32'b0001);
    chk("w1_wr_drop", 32'(mem_write_o), 0);
    chk("w1_acc_addr", 32'(acc_addr), 32'h10);
    req_i = '0;
    step();
    chk("w1_gnt_pulse", 32'(gnt_o), 0);
    m_ptr = 1;

    // write stretched by 5 waitrequest cycles
    cfg_wait = 5;
    a = AW'($urandom); d = DW'($urandom);
    req_we_i[1] = 1'b1; req_addr_i[1] = a; req_wdata_i[1] = d; req_i = 4'b0010;
    hi = 0; bad = 0; gcnt = 0; last_g = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_write_o) begin
        hi++;
        if (mem_addr_o !== a || mem_wdata_o !== d) bad++;
      end
      if (gnt_o != '0) begin gcnt++; last_g = gnt_o; req_i = '0; end
    end
    chk("ws_strobe_cycles", 32'(hi), 6);
    chk("ws_unstable", 32'(bad), 0);
    chk("ws_gnt_count", 32'(gcnt), 1);
    chk("ws_gnt", 32'(last_g), 32'b0010);
    cfg_wait = 0;

    // randomized traffic from reset; first five are continuous reads
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_we_i[i] = 1'b0; req_addr_i[i] = AW'($urandom); req_wdata_i[i] = DW'($urandom);
    end
    req_i = '1; snap = '1; ng = 0; cyc = 0;
    while (ng < 24 && cyc < 3000) begin
      step(); cyc++;
      if (gnt_o != '0) begin
        w = pick(snap, m_ptr);
        if (w < 0) w = 0;
        eg = '0; eg[w] = 1'b1;
        if (ng < 5) begin
          eg = '0; eg[ord[ng]] = 1'b1;
          chk("rr_order", 32'(gnt_o), 32'(eg));
          eg = '0; eg[w] = 1'b1;
        end
        chk("tr_gnt", 32'(gnt_o), 32'(eg));
        chk("tr_acc_we", 32'(acc_we), 32'(req_we_i[w]));
        chk("tr_acc_addr", 32'(acc_addr), 32'(req_addr_i[w]));
        if (req_we_i[w]) chk("tr_acc_wdata", 32'(acc_wdata), 32'(req_wdata_i[w]));
        else exp_rdata = rd_val(req_addr_i[w]);
        chk("tr_rdata", 32'(rdata_o), 32'(exp_rdata));
        chk("tr_err", 32'(err_o), 0);
        m_ptr = (w + 1) % NR;
        ng++;
        if (ng == 24) req_i = '0;
        else if (ng < 5) req_addr_i[w] = AW'($urandom);
        else begin
          req_we_i[w] = 1'($urandom_range(0, 1));
          req_addr_i[w] = AW'($urandom); req_wdata_i[w] = DW'($urandom);
          req_i[w] = ($urandom_range(0, 3) != 0);
          if (req_i == '0) req_i = NR'($urandom_range(1, (1 << NR) - 1));
          cfg_wait = $urandom_range(0, 3); cfg_lat = $urandom_range(1, 4);
        end
        snap = req_i;
      end
    end
    chk("tr_grants", 32'(ng), 24);
    cfg_wait = 0; cfg_lat = 3;

    // spurious rdatavalid while idle
    step();
    cfg_spur = 1'b1;
    step();
    cfg_spur = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (gnt_o != '0) bad++;
      step();
    end
    chk("spur_gnt", 32'(bad), 0);
    chk("spur_rdata", 32'(rdata_o), 32'(exp_rdata));
    chk("spur_busy", 32'(busy_o), 0);

    // request dropped after arbitration still completes
    a = AW'($urandom);
    req_we_i[2] = 1'b0; req_addr_i[2] = a; req_i = 4'b0100;
    step();
    chk("drop_busy", 32'(busy_o), 1);
    req_i = '0;
    wait_gnt(20, cyc, got);
    chk("drop_seen", 32'(got), 1);
    chk("drop_gnt", 32'(gnt_o), 32'b0100);
    chk("drop_rdata", 32'(rdata_o), 32'(rd_val(a)));
    exp_rdata = rd_val(a); m_ptr = 3;

    // reset while waiting for read data
    cfg_answer = 1'b0;
    req_we_i[3] = 1'b0; req_addr_i[3] = AW'($urandom); req_i = 4'b1000;
    step(); step(); step();
    chk("rwr_busy", 32'(busy_o), 1);
    req_i = '0;
    arst_n_i = 1'b0;
    #1;
    chk_zero("rwr");
    bad = 0;
    for (int i = 0; i < 2; i++) begin step(); if (gnt_o != '0) bad++; end
    chk("rwr_no_gnt", 32'(bad), 0);
    arst_n_i = 1'b1; cfg_answer = 1'b1; m_ptr = 0; exp_rdata = '0;
    step();
    req_we_i[0] = 1'b1; req_addr_i[0] = AW'($urandom); req_wdata_i[0] = DW'($urandom);
    req_we_i[3] = 1'b1; req_addr_i[3] = AW'($urandom); req_wdata_i[3] = DW'($urandom);
    req_i = 4'b1001;
    wait_gnt(20, cyc, got);
    chk("post_rst_seen", 32'(got), 1);
    chk("post_rst_first", 32'(gnt_o), 32'b0001);
    req_i[0] = 1'b0;
    wait_gnt(20, cyc, got);
    chk("post_rst_second", 32'(gnt_o), 32'b1000);
    req_i = '0;
    step();

    // unanswered read: watchdog or indefinite wait
    cfg_answer = 1'b0;
    req_we_i[1] = 1'b0; req_addr_i[1] = AW'($urandom); req_i = 4'b0010;
    wait_gnt(60, cyc, got);
    req_i = '0;
`ifdef MEM_PORT_SCHEDULER_TIMEOUT_EN
    chk("to_seen", 32'(got), 1);
    chk("to_latency", 32'(cyc), 18);
    chk("to_gnt", 32'(gnt_o), 32'b0010);
    chk("to_err", 32'(err_o), 1);
    chk("to_rdata", 32'(rdata_o), 0);
    step();
    chk("to_err_pulse", 32'(err_o), 0);
    chk("to_gnt_pulse", 32'(gnt_o), 0);
`else
    chk("nto_no_gnt", 32'(got), 0);
    chk("nto_err", 32'(err_o), 0);
    chk("nto_busy", 32'(busy_o), 1);
    do_reset();
`endif
    cfg_answer = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_scheduler.md
MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 23, memory word address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, read-response watchdog limit.
REQ-005 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port arst_n_i  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_i  input  NUM_REQ  per-requester request, held until gnt_o.
REQ-008 SHALL have port req_we_i  input  NUM_REQ  per-requester write (1) / read (0).
REQ-009 SHALL have port req_addr_i  input  NUM_REQ x ADDR_WIDTH  per-requester address.
REQ-010 SHALL have port req_wdata_i  input  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-011 SHALL have port gnt_o  output  NUM_REQ  one-hot one-cycle completion pulse.
REQ-012 SHALL have port rdata_o  output  DATA_WIDTH  read data, valid with gnt_o of a read.
REQ-013 SHALL have port err_o  output  1  pulse with gnt_o when a read timed out.
REQ-014 SHALL have ports mem_read_o, mem_write_o  output  1 each  memory command strobes.
REQ-015 SHALL have ports mem_addr_o  output  ADDR_WIDTH; mem_wdata_o  output  DATA_WIDTH.
REQ-016 SHALL have ports mem_waitrequest_i, mem_rdatavalid_i  input  1; mem_rdata_i  input  DATA_WIDTH.
REQ-017 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM IDLE -> CMD -> (write: IDLE | read: WAIT_RD -> IDLE); one transaction outstanding.
REQ-019 SHALL in IDLE, on any req_i bit, pick winner round-robin from pointer rr_ptr, latch winner's we/addr/wdata, enter CMD next cycle.
REQ-020 SHALL drive mem_read_o/mem_write_o registered, held high throughout CMD, command fields stable until accepted.
REQ-021 SHALL treat command accepted on a CMD cycle with mem_waitrequest_i low.
REQ-022 SHALL on accepted write pulse gnt_o[winner] the following cycle and return to IDLE; minimum req-to-gnt latency 2 cycles.
REQ-023 SHALL on accepted read enter WAIT_RD; on mem_rdatavalid_i register mem_rdata_i to rdata_o and pulse gnt_o[winner] next cycle.
REQ-024 SHALL set rr_ptr to winner+1 (wrap NUM_REQ-1 -> 0) at each completion; lowest index from rr_ptr upward wins.
REQ-025 SHALL ignore req_i changes while not IDLE; a dropped request still completes.
REQ-026 SHALL ignore mem_rdatavalid_i outside WAIT_RD.
REQ-027 SHALL hold rdata_o between read completions; gnt_o never multi-hot.
REQ-028 SHALL allow a new arbitration in the cycle after gnt_o (back-to-back, 1 IDLE cycle).

Reset
REQ-029 SHALL on arst_n_i low asynchronously force state IDLE, rr_ptr 0, gnt_o 0, err_o 0, rdata_o 0, mem strobes 0, mem_addr_o/mem_wdata_o 0, busy_o 0.
REQ-030 SHALL abandon any in-flight transaction on reset without issuing gnt_o.

Configuration
REQ-031 SHALL compile the read watchdog only when macro MEM_PORT_SCHEDULER_TIMEOUT_EN is defined.
REQ-032 SHALL with the macro count WAIT_RD cycles; at TIMEOUT_CYCLES return to IDLE with gnt_o[winner], rdata_o 0, err_o pulse.
REQ-033 SHALL without the macro wait in WAIT_RD indefinitely and tie err_o to 0.

Structure
REQ-034 SHALL place FSM state enum and TIMEOUT counter width constant in shared package mem_port_scheduler_pkg.
REQ-035 SHALL implement winner selection in sub-module rr_arbiter (combinational pick given req and pointer).

Verification
REQ-036 Single write req_i=0001, addr 0x10, data 0xABCD, waitrequest low -> mem_write_o 1 cycle, gnt_o=0001 2 cycles after req.
REQ-037 All four requesting reads continuously, rdatavalid 3 cycles after accept -> gnt order 0,1,2,3,0, rdata_o matches each.
REQ-038 Write with waitrequest high 5 cycles -> command fields stable 6 cycles, gnt_o once after release.
REQ-039 Reset asserted in WAIT_RD -> all outputs 0 immediately, no gnt_o; next request served from index 0.
REQ-040 With macro, read never answered, TIMEOUT_CYCLES=16 -> gnt_o and err_o pulse after 16 WAIT_RD cycles, rdata_o 0.
REQ-041 Spurious mem_rdatavalid_i in IDLE -> no gnt_o, rdata_o unchanged.
